cpu_oam_dma: RTL and testbench

Sprite-DMA engine between the `cpu_6502` core and the CPU memory bus. It passes CPU bus traffic through unchanged until the CPU writes the DMA register. It then halts the CPU and copies one 256-byte page from CPU address space to the PPU OAM data port, one byte per read/write cycle pair. It returns bus ownership to the CPU when the copy completes.

---
 rtl/cpu_oam_dma.sv | 110 +++++++++++
 tb/tb_cpu_oam_dma.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_oam_dma.sv
// Sprite DMA: passes CPU bus traffic through until the DMA register is written, then halts
// the CPU and copies one 256-byte page into the OAM data port as read/write cycle pairs.
module cpu_oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_mem_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_write_en,
    input  logic        cpu_read_en,
    input  logic [7:0]  bus_data_in,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data_out,
    output logic        bus_write_en,
    output logic        bus_read_en,
    output logic        cpu_halt,
    output logic        dma_active
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t      state;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic        parity;
    logic        halt_q;

    wire trigger = cpu_write_en && (cpu_mem_addr == DMA_REG_ADDR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            page   <= 8'h00;
            idx    <= 8'h00;
            parity <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            parity <= ~parity;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        page   <= cpu_data_out;
                        idx    <= 8'h00;
                        halt_q <= 1'b1;
                        state  <= HALT;
                    end
                end
                // Reads must land on even cycles; parity=1 now means the next cycle is even.
                HALT:  state <= parity ? READ : ALIGN;
                ALIGN: state <= READ;
                READ:  state <= WRITE;
                WRITE: begin
                    if (idx == 8'hFF) begin
                        halt_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= READ;
                    end
                end
                default: begin
                    halt_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign cpu_halt   = halt_q;
    assign dma_active = halt_q;

    // While the DMA owns the bus the CPU-side inputs never reach the bus.
    always_comb begin
        bus_addr     = cpu_mem_addr;
        bus_data_out = cpu_data_out;
        bus_write_en = cpu_write_en;
        bus_read_en  = cpu_read_en;
        case (state)
            IDLE: begin
            end
            READ: begin
                bus_addr     = {page, idx};
                bus_data_out = 8'h00;
                bus_write_en = 1'b0;
                bus_read_en  = 1'b1;
            end
            WRITE: begin
                bus_addr     = OAM_DATA_ADDR;
                bus_data_out = bus_data_in;
                bus_write_en = 1'b1;
                bus_read_en  = 1'b0;
            end
            default: begin
                bus_addr     = {page, idx};
                bus_data_out = 8'h00;
                bus_write_en = 1'b0;
                bus_read_en  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_oam_dma.sv
// Bench for cpu_oam_dma: randomized CPU traffic against a page-copy reference model.
module tb_cpu_oam_dma;

    localparam logic [15:0] DMA_REG = 16'h4014;
    localparam logic [15:0] OAM_REG = 16'h2004;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_mem_addr = 16'h0000;
    logic [7:0]  cpu_data_out = 8'h00;
    logic        cpu_write_en = 1'b0;
    logic        cpu_read_en = 1'b0;
    logic [7:0]  bus_data_in;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_out;
    logic        bus_write_en;
    logic        bus_read_en;
    logic        cpu_halt;
    logic        dma_active;

    logic [7:0]  mem [0:65535];
    logic [7:0]  rdata = 8'h00;
    logic [31:0] cyc = 32'd0;
    int          n_pass = 0;
    int          n_total = 0;

    cpu_oam_dma dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_mem_addr (cpu_mem_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_write_en (cpu_write_en),
        .cpu_read_en  (cpu_read_en),
        .bus_data_in  (bus_data_in),
        .bus_addr     (bus_addr),
        .bus_data_out (bus_data_out),
        .bus_write_en (bus_write_en),
        .bus_read_en  (bus_read_en),
        .cpu_halt     (cpu_halt),
        .dma_active   (dma_active)
    );

    always #5 clk = ~clk;

    // Memory answers one cycle after the read address.
    always @(posedge clk) if (bus_read_en === 1'b1) rdata <= mem[bus_addr];
    assign bus_data_in = rdata;

    // Cycle count since reset release; its LSB is the parity of the current cycle.
    always @(posedge clk) begin
        if (!rst) cyc <= 32'd0;
        else      cyc <= cyc + 32'd1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_wr(input logic [15:0] a, input logic [7:0] d);
        cpu_mem_addr = a;
        cpu_data_out = d;
        cpu_write_en = 1'b1;
        cpu_read_en  = 1'b0;
    endtask

    task automatic drive_benign();
        cpu_mem_addr = 16'($urandom);
        cpu_data_out = 8'($urandom);
        cpu_write_en = 1'b0;
        cpu_read_en  = 1'($urandom);
    endtask

    function automatic logic [26:0] bus_obs();
        return {bus_addr, bus_data_out, bus_write_en, bus_read_en, cpu_halt};
    endfunction

    function automatic logic [26:0] pass_exp();
        return {cpu_mem_addr, cpu_data_out, cpu_write_en, cpu_read_en, 1'b0};
    endfunction

    // Issue the trigger write in a cycle of the requested parity; report the expected halt length.
    task automatic trigger(input logic [7:0] pg, input bit odd, output int exp_halt);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (cyc[0] == odd) break;
            drive_benign();
        end
        drive_wr(DMA_REG, pg);
        exp_halt = odd ? 514 : 513;
        @(negedge clk);
        chk("trig_pass", 32'(bus_obs()), 32'({DMA_REG, pg, 2'b10, 1'b0}));
    endtask

    // Observe one transfer from the cycle after the trigger until cpu_halt drops.
    task automatic run_xfer(input logic [7:0] pg, input int exp_halt, input bit chain,
                            input logic [7:0] nxt, output int nxt_halt);
        logic [15:0] rd_q[$];
        logic [15:0] wa_q[$];
        logic [7:0]  wd_q[$];
        int hc, first_rd, idle_c, order_err, act_err, addr_err, data_err;
        bit want_wr;
        hc = 0; first_rd = -1; idle_c = 0; order_err = 0; act_err = 0;
        addr_err = 0; data_err = 0; want_wr = 0; nxt_halt = 0;
        for (int k = 1; k <= 600; k++) begin
            @(posedge clk); #1;
            if (k <= exp_halt) begin
                cpu_write_en = 1'($urandom);
                cpu_read_en  = 1'($urandom);
                cpu_data_out = 8'($urandom);
                cpu_mem_addr = (k % 4 == 0) ? DMA_REG : 16'($urandom);
            end else if (chain) begin
                drive_wr(DMA_REG, nxt);
                nxt_halt = cyc[0] ? 514 : 513;
            end else begin
                drive_benign();
            end
            @(negedge clk);
            if (dma_active !== cpu_halt) act_err++;
            if (cpu_halt !== 1'b1) break;
            hc++;
            if (bus_read_en === 1'b1 && bus_write_en === 1'b1) order_err++;
            else if (bus_read_en === 1'b1) begin
                if (first_rd < 0) first_rd = k;
                if (want_wr) order_err++;
                want_wr = 1;
                rd_q.push_back(bus_addr);
            end else if (bus_write_en === 1'b1) begin
                if (!want_wr) order_err++;
                want_wr = 0;
                wa_q.push_back(bus_addr);
                wd_q.push_back(bus_data_out);
            end else idle_c++;
        end
        chk("final_pass", 32'(bus_obs()), 32'(pass_exp()));
        chk("halt_len", hc, exp_halt);
        chk("first_read", first_rd, exp_halt - 511);
        chk("idle_cycles", idle_c, exp_halt - 512);
        chk("rw_order", order_err, 0);
        chk("active_eq_halt", act_err, 0);
        chk("read_count", rd_q.size(), 256);
        chk("write_count", wa_q.size(), 256);
        for (int i = 0; i < 256 && i < rd_q.size(); i++)
            if (rd_q[i] !== {pg, 8'(i)}) addr_err++;
        for (int i = 0; i < 256 && i < wa_q.size(); i++) begin
            if (wa_q[i] !== OAM_REG) addr_err++;
            if (wd_q[i] !== mem[{pg, 8'(i)}]) data_err++;
        end
        chk("addr_seq", addr_err, 0);
        chk("data_seq", data_err, 0);
    endtask

    initial begin
        int eh, nh, wcount, errs;
        bit hit;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[{8'h03, 8'(i)}] = 8'(i) ^ 8'h5A;
        chk("page3_first", 32'(mem[16'h0300]), 32'h5A);
        chk("page3_last", 32'(mem[16'h03FF]), 32'hA5);

        // Reset held with random CPU traffic, including a write to the DMA register.
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (c == 2) drive_wr(DMA_REG, 8'h03);
            else begin
                cpu_mem_addr = 16'($urandom);
                cpu_data_out = 8'($urandom);
                cpu_write_en = 1'($urandom);
                cpu_read_en  = 1'($urandom);
            end
            @(negedge clk);
            chk("rst_pass", 32'(bus_obs()), 32'(pass_exp()));
        end
        @(posedge clk); #1;
        rst = 1'b1;
        drive_benign();
        @(negedge clk);
        chk("rst_release", 32'(bus_obs()), 32'(pass_exp()));

        // Even trigger, then odd trigger on the same page.
        trigger(8'h03, 1'b0, eh);
        chk("even_exp", eh, 513);
        run_xfer(8'h03, eh, 1'b0, 8'h00, nh);
        trigger(8'h03, 1'b1, eh);
        run_xfer(8'h03, eh, 1'b0, 8'h00, nh);

        // Top page, chained back-to-back into page 3.
        trigger(8'hFF, 1'($urandom), eh);
        run_xfer(8'hFF, eh, 1'b1, 8'h03, nh);
        run_xfer(8'h03, nh, 1'b0, 8'h00, nh);

        // Reset right after the write of idx 100.
        trigger(8'h03, 1'b0, eh);
        wcount = 0; hit = 0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            drive_benign();
            @(negedge clk);
            if (bus_write_en === 1'b1 && bus_addr === OAM_REG) wcount++;
            if (wcount == 101) begin
                hit = 1;
                break;
            end
        end
        chk("mid_reach", 32'(hit), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        drive_benign();
        @(negedge clk);
        chk("mid_rst_nowrite", 32'(bus_write_en), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive_benign();
        @(negedge clk);
        chk("mid_idle", 32'(bus_obs()), 32'(pass_exp()));
        errs = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            drive_benign();
            @(negedge clk);
            if (cpu_halt !== 1'b0 || bus_write_en !== 1'b0) errs++;
        end
        chk("mid_quiet", errs, 0);
        trigger(8'h04, 1'($urandom), eh);
        run_xfer(8'h04, eh, 1'b0, 8'h00, nh);

        // Accesses that must not trigger.
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            if (t == 0) begin
                cpu_mem_addr = DMA_REG;
                cpu_data_out = 8'($urandom);
                cpu_write_en = 1'b0;
                cpu_read_en  = 1'b1;
            end else drive_wr((t == 1) ? 16'h4015 : 16'h4004, 8'($urandom));
            @(negedge clk);
            chk("nontrig_pass", 32'(bus_obs()), 32'(pass_exp()));
            @(posedge clk); #1;
            drive_benign();
            @(negedge clk);
            chk("nontrig_nohalt", 32'({cpu_halt, dma_active}), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
